// File: rtl/layer_pkg.sv
// Package: layer_pkg
// Shared types and constants for the layer stream blocks.
//   tx_state_t  - transmit FSM state (IDLE, SEND, DONE)
//   FIFO_DEPTH  - entries in the output-stage FIFO in front of the stream port
package layer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } tx_state_t;

    localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/layer_x_stream_tx_if.sv
// Interface: layer_x_stream_tx_if
// Valid/ready word stream from the vector transmitter to a conv layer input.
//   m_data_out_x  WIDTH  stream data (signed word, passed through unmodified)
//   m_valid_x     1      data valid, driven by the master
//   m_ready_x     1      consumer ready, driven by the slave
// modport master: transmitter side; modport slave: consumer side.
interface layer_x_stream_tx_if #(
    parameter int WIDTH = 16
) ();

    logic [WIDTH-1:0] m_data_out_x;
    logic             m_valid_x;
    logic             m_ready_x;

    modport master (
        output m_data_out_x,
        output m_valid_x,
        input  m_ready_x
    );

    modport slave (
        input  m_data_out_x,
        input  m_valid_x,
        output m_ready_x
    );

endinterface

// File: rtl/layer_stream_fifo2.sv
// Module: layer_stream_fifo2
// Two-entry registered FIFO; the head is always entry 0 so the output is a flop.
//   clk, reset  in   clock, asynchronous active-high reset (clears count and data)
//   push, din   in   write request and data; dropped when full without a pop
//   pop         in   remove head; ignored when empty
//   head        out  oldest entry
//   count       out  occupancy 0..2
//   full, empty out  occupancy flags
module layer_stream_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] e0_q, e1_q;
    logic [1:0]       count_q;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
        head    = e0_q;
        count   = count_q;
        full    = (count_q == 2'd2);
        empty   = (count_q == 2'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) e0_q <= din;
                    else                 e1_q <= din;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    // Keep the last word on the head when draining to empty.
                    if (count_q == 2'd2) e0_q <= e1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        e0_q <= din;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/memory.sv
// Module: memory
// Single-port word buffer with synchronous read (1-cycle latency) and no reset.
//   clk      in   clock
//   wr_en    in   write strobe; writes to addr >= LENX are dropped
//   addr     in   shared read/write address
//   wr_data  in   write data
//   rd_data  out  registered read data for the address seen at the previous edge
module memory #(
    parameter int WIDTH = 16,
    parameter int LENX  = 24,
    parameter int ADDRX = 5
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [ADDRX-1:0] addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [LENX];
    logic             addr_ok;

    always_comb begin
        addr_ok = (int'(addr) < LENX);
    end

    always_ff @(posedge clk) begin
        if (wr_en && addr_ok) begin
            mem[addr] <= wr_data;
        end
        rd_data <= mem[addr];
    end

endmodule

// File: rtl/layer_x_stream_tx.sv
// Module: layer_x_stream_tx
// Buffers one LENX-word input vector written through a random-access load port and, on
// start, streams it in address order over a valid/ready interface.
//   clk, reset   in   clock, asynchronous active-high reset
//   ld_data_in   in   load-port write data
//   ld_addr      in   load-port write address (0..LENX-1, others ignored)
//   ld_wr_en     in   load-port write strobe, honoured only in IDLE
//   start        in   begin transmitting, honoured only in IDLE
//   busy         out  high in SEND and DONE
//   done         out  one-cycle pulse after the final handshake
//   m_x          master modport: m_data_out_x, m_valid_x out; m_ready_x in
module layer_x_stream_tx
    import layer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LENX  = 24,
    parameter int ADDRX = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ld_data_in,
    input  logic [ADDRX-1:0] ld_addr,
    input  logic             ld_wr_en,
    input  logic             start,
    output logic             busy,
    output logic             done,
    layer_x_stream_tx_if.master m_x
);

    // One extra bit so rd_addr can rest at LENX even when LENX is a power of two.
    localparam int CW = ADDRX + 1;

    tx_state_t        state_q, state_d;
    logic [CW-1:0]    rd_addr_q, tx_count_q;
    logic             in_flight_q;

    logic             rd_issue, pop, last_hs;
    logic [1:0]       occupancy;
    logic [ADDRX-1:0] mem_addr;
    logic             mem_we;
    logic [WIDTH-1:0] mem_rd;

    logic [WIDTH-1:0] fifo_head;
    logic [1:0]       fifo_count;
    logic             fifo_full, fifo_empty;

    memory #(
        .WIDTH (WIDTH),
        .LENX  (LENX),
        .ADDRX (ADDRX)
    ) u_buf (
        .clk     (clk),
        .wr_en   (mem_we),
        .addr    (mem_addr),
        .wr_data (ld_data_in),
        .rd_data (mem_rd)
    );

    // A read issued last cycle lands in mem_rd now and is pushed straight in.
    layer_stream_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_flight_q),
        .pop   (pop),
        .din   (mem_rd),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_x.m_data_out_x = fifo_head;
    assign m_x.m_valid_x    = !fifo_empty;

    always_comb begin
        pop       = !fifo_empty && m_x.m_ready_x;
        occupancy = fifo_count + {1'b0, in_flight_q};
        // A pop this cycle frees a slot; without it the pipe would bubble every other
        // word under continuous ready. Occupancy (FIFO + in-flight) never exceeds 2.
        rd_issue  = (state_q == SEND) && (rd_addr_q < CW'(LENX)) &&
                    ((occupancy < 2'(FIFO_DEPTH)) || pop);
        last_hs   = pop && (tx_count_q == CW'(LENX - 1));
        mem_we    = (state_q == IDLE) && ld_wr_en;
        mem_addr  = (state_q == IDLE) ? ld_addr : rd_addr_q[ADDRX-1:0];
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);

        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)   state_d = SEND;
            SEND:    if (last_hs) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            tx_count_q  <= '0;
            in_flight_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_flight_q <= rd_issue;
            if (state_q == IDLE) begin
                rd_addr_q  <= '0;
                tx_count_q <= '0;
            end else begin
                if (rd_issue) rd_addr_q  <= rd_addr_q + 1'b1;
                if (pop)      tx_count_q <= tx_count_q + 1'b1;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(fifo_full && in_flight_q));

endmodule

// File: tb/tb_layer_x_stream_tx.sv
module tb_layer_x_stream_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ld_data_in;
    logic [4:0]  ld_addr;
    logic        ld_wr_en;
    logic        start;
    logic        busy;
    logic        done;

    layer_x_stream_tx_if #(.WIDTH(16)) sx ();

    layer_x_stream_tx #(
        .WIDTH (16),
        .LENX  (24),
        .ADDRX (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_data_in (ld_data_in),
        .ld_addr    (ld_addr),
        .ld_wr_en   (ld_wr_en),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .m_x        (sx)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;

    logic [15:0] got [64];
    int          n_got, done_cnt, valid_run, stable_err, post_err, first_valid, stall_cyc;
    bit          timeout;

    // Vector 0: 100+k. Vector 1: signed extremes in words 0..2, 100+k elsewhere.
    function automatic logic [15:0] exp_word(input int vec, input int k);
        logic [15:0] w;
        w = 16'(100 + k);
        if (vec == 1) begin
            if (k == 0) w = 16'h8000;
            if (k == 1) w = 16'h7FFF;
            if (k == 2) w = 16'hFFFF;
        end
        return w;
    endfunction

    task automatic load_vec(input int vec);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            ld_wr_en   = 1'b1;
            ld_addr    = 5'(k);
            ld_data_in = exp_word(vec, k);
        end
        // Out-of-range address must not disturb anything.
        @(negedge clk);
        ld_addr    = 5'd24;
        ld_data_in = 16'hDEAD;
        @(negedge clk);
        ld_wr_en = 1'b0;
    endtask

    // Runs the consumer side one cycle per negedge and records accepted words.
    // mode 0: ready always; 1: ready 1-0-1-0; 2: ready low 10 cycles after first valid.
    task automatic collect(input int mode, input int budget, input int stop_at,
                           input bit inject, input bit restart);
        int          since;
        bit          seen_valid, run_open, prev_stall, saw_done, r;
        logic [15:0] prev_data;
        for (int i = 0; i < 64; i++) got[i] = 'x;
        n_got = 0; done_cnt = 0; valid_run = 0; stable_err = 0; post_err = 0;
        first_valid = -1; stall_cyc = 0; timeout = 1'b1;
        since = 0; seen_valid = 0; run_open = 1; prev_stall = 0; saw_done = 0;
        prev_data = '0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            start    = 1'b0;
            ld_wr_en = 1'b0;
            if (prev_stall && (sx.m_valid_x !== 1'b1 || sx.m_data_out_x !== prev_data))
                stable_err++;
            if (saw_done && done !== 1'b1) begin
                if (sx.m_valid_x !== 1'b0 || busy !== 1'b0) post_err++;
                if (restart) start = 1'b1;
                timeout = 1'b0;
                break;
            end
            if (done === 1'b1) begin
                done_cnt++;
                saw_done = 1'b1;
                if (sx.m_valid_x !== 1'b0) post_err++;
            end
            if (sx.m_valid_x === 1'b1) begin
                if (!seen_valid) first_valid = cyc;
                seen_valid = 1'b1;
                if (run_open) valid_run++;
            end else if (seen_valid) begin
                run_open = 1'b0;
            end
            case (mode)
                1:       r = (cyc % 2 == 0);
                2:       r = !(seen_valid && since < 10);
                default: r = 1'b1;
            endcase
            if (seen_valid) since++;
            if (inject && cyc == 4) begin
                ld_wr_en   = 1'b1;
                ld_addr    = 5'd5;
                ld_data_in = 16'hFFF9;
                start      = 1'b1;
            end
            sx.m_ready_x = r;
            if (sx.m_valid_x === 1'b1 && r) begin
                if (n_got < 64) got[n_got] = sx.m_data_out_x;
                n_got++;
            end
            if (sx.m_valid_x === 1'b1 && !r) stall_cyc++;
            prev_stall = (sx.m_valid_x === 1'b1) && !r;
            prev_data  = sx.m_data_out_x;
            if (stop_at > 0 && n_got == stop_at) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; ld_data_in = '0; ld_addr = '0; ld_wr_en = 1'b0; start = 1'b0;
        sx.m_ready_x = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++;
        if (sx.m_valid_x !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", sx.m_valid_x);
        end
        n_tests++;
        if (sx.m_data_out_x !== 16'h0000) begin
            n_fail++; $display("FAIL reset_data: got %h want 0000", sx.m_data_out_x);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        load_vec(0);
        @(negedge clk); start = 1'b1;
        collect(0, 200, 0, 1'b0, 1'b0);
        n_tests++; if (timeout) begin n_fail++; $display("FAIL basic_timeout: no done within budget"); end
        n_tests++; if (n_got !== 24) begin n_fail++; $display("FAIL basic_count: got %0d want 24", n_got); end
        for (int k = 0; k < 24; k++) begin
            n_tests++;
            if (got[k] !== exp_word(0, k)) begin
                n_fail++; $display("FAIL basic_word%0d: got %h want %h", k, got[k], exp_word(0, k));
            end
        end
        n_tests++;
        if (first_valid !== 2) begin
            n_fail++; $display("FAIL basic_latency: got %0d want 2", first_valid);
        end
        n_tests++; if (valid_run !== 24) begin n_fail++; $display("FAIL basic_run: got %0d want 24", valid_run); end
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done: got %0d want 1", done_cnt); end
        n_tests++; if (post_err !== 0) begin n_fail++; $display("FAIL basic_post: got %0d want 0", post_err); end
    endtask

    task automatic test_toggle;
        @(negedge clk); start = 1'b1;
        collect(1, 300, 0, 1'b0, 1'b0);
        n_tests++; if (n_got !== 24) begin n_fail++; $display("FAIL toggle_count: got %0d want 24", n_got); end
        for (int k = 0; k < 24; k++) begin
            n_tests++;
            if (got[k] !== exp_word(0, k)) begin
                n_fail++; $display("FAIL toggle_word%0d: got %h want %h", k, got[k], exp_word(0, k));
            end
        end
        n_tests++; if (stable_err !== 0) begin n_fail++; $display("FAIL toggle_stable: got %0d want 0", stable_err); end
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL toggle_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_stall;
        @(negedge clk); start = 1'b1;
        collect(2, 300, 0, 1'b0, 1'b0);
        n_tests++; if (stall_cyc !== 10) begin n_fail++; $display("FAIL stall_cycles: got %0d want 10", stall_cyc); end
        n_tests++; if (stable_err !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d want 0", stable_err); end
        n_tests++; if (valid_run !== 34) begin n_fail++; $display("FAIL stall_run: got %0d want 34", valid_run); end
        n_tests++; if (n_got !== 24) begin n_fail++; $display("FAIL stall_count: got %0d want 24", n_got); end
        for (int k = 0; k < 24; k++) begin
            n_tests++;
            if (got[k] !== exp_word(0, k)) begin
                n_fail++; $display("FAIL stall_word%0d: got %h want %h", k, got[k], exp_word(0, k));
            end
        end
    endtask

    task automatic test_ignored;
        int extra;
        // Write to addr 5 and start pulse while SEND: both dropped.
        @(negedge clk); start = 1'b1;
        collect(0, 200, 0, 1'b1, 1'b0);
        n_tests++; if (n_got !== 24) begin n_fail++; $display("FAIL busy_count: got %0d want 24", n_got); end
        n_tests++; if (got[5] !== 16'd105) begin n_fail++; $display("FAIL busy_write: got %h want 0069", got[5]); end
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL busy_done: got %0d want 1", done_cnt); end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (sx.m_valid_x !== 1'b0 || busy !== 1'b0) extra++;
        end
        n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL busy_restart: got %0d active cycles want 0", extra); end
        // Write and start in the same IDLE cycle: the new word is sent.
        @(negedge clk);
        ld_wr_en = 1'b1; ld_addr = 5'd5; ld_data_in = 16'hFFF9; start = 1'b1;
        collect(0, 200, 0, 1'b0, 1'b0);
        n_tests++; if (got[5] !== 16'hFFF9) begin n_fail++; $display("FAIL idle_write: got %h want fff9", got[5]); end
        n_tests++; if (got[4] !== 16'd104) begin n_fail++; $display("FAIL idle_word4: got %h want 0068", got[4]); end
        n_tests++; if (got[23] !== 16'd123) begin n_fail++; $display("FAIL idle_word23: got %h want 007b", got[23]); end
    endtask

    task automatic test_reset_mid;
        int dcount;
        load_vec(0);
        @(negedge clk); start = 1'b1;
        collect(0, 200, 12, 1'b0, 1'b0);
        n_tests++; if (got[11] !== 16'd111) begin n_fail++; $display("FAIL mid_word11: got %h want 006f", got[11]); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_tests++; if (sx.m_valid_x !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", sx.m_valid_x); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
        reset = 1'b0;
        dcount = 0;
        repeat (5) begin
            @(negedge clk);
            if (done !== 1'b0) dcount++;
        end
        n_tests++; if (dcount !== 0) begin n_fail++; $display("FAIL mid_nodone: got %0d want 0", dcount); end
        @(negedge clk); start = 1'b1;
        collect(0, 200, 0, 1'b0, 1'b0);
        n_tests++; if (n_got !== 24) begin n_fail++; $display("FAIL mid_count: got %0d want 24", n_got); end
        for (int k = 0; k < 24; k++) begin
            n_tests++;
            if (got[k] !== exp_word(0, k)) begin
                n_fail++; $display("FAIL mid_word%0d: got %h want %h", k, got[k], exp_word(0, k));
            end
        end
    endtask

    task automatic test_back_to_back;
        load_vec(1);
        @(negedge clk); start = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            collect(0, 200, 0, 1'b0, pass == 0);
            n_tests++;
            if (n_got !== 24) begin
                n_fail++; $display("FAIL b2b%0d_count: got %0d want 24", pass, n_got);
            end
            n_tests++;
            if (first_valid !== 2) begin
                n_fail++; $display("FAIL b2b%0d_latency: got %0d want 2", pass, first_valid);
            end
            for (int k = 0; k < 24; k++) begin
                n_tests++;
                if (got[k] !== exp_word(1, k)) begin
                    n_fail++;
                    $display("FAIL b2b%0d_word%0d: got %h want %h", pass, k, got[k], exp_word(1, k));
                end
            end
            n_tests++;
            if (done_cnt !== 1) begin
                n_fail++; $display("FAIL b2b%0d_done: got %0d want 1", pass, done_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_stall();
        test_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
